// File: rtl/ao_periph_obi_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ao_periph_arb_pkg
// Arbiter-local constants and types.
//   arb_id_width()  : requester-ID width, clog2(num_req) with a floor of 1
//   tracker_entry_t : one ID-tracker entry sized for the largest supported
//                     requester count
// -----------------------------------------------------------------------------
package ao_periph_arb_pkg;

  localparam int unsigned ARB_MAX_REQ  = 8;
  localparam int unsigned ARB_ID_MAX_W = 3;

  function automatic int unsigned arb_id_width(input int unsigned num_req);
    arb_id_width = (num_req <= 32'd2) ? 32'd1 : $clog2(num_req);
  endfunction

  typedef logic [ARB_ID_MAX_W-1:0] tracker_entry_t;

endpackage

// File: rtl/obi_pkg.sv
// -----------------------------------------------------------------------------
// obi_pkg
// Shared OBI bus types used by the always-on peripheral arbiter.
//   obi_req_t  : req, we, be, addr, wdata (requester -> slave)
//   obi_resp_t : gnt, rvalid, rdata      (slave -> requester)
// -----------------------------------------------------------------------------
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/ao_periph_obi_arbiter_if.sv
// -----------------------------------------------------------------------------
// ao_periph_obi_arbiter_if
// Bundles the requester-side and slave-side OBI signals of the arbiter.
//   master modport : the arbiter's view (drives slave_req, master_resp,
//                    busy, err; samples master_req, slave_resp)
//   slave modport  : the environment's view (requesters plus AO slave)
// -----------------------------------------------------------------------------
interface ao_periph_obi_arbiter_if
  import obi_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  obi_req_t  master_req  [NUM_REQ];
  obi_resp_t master_resp [NUM_REQ];
  obi_req_t  slave_req;
  obi_resp_t slave_resp;
  logic      busy;
  logic      err;

  modport master (
    input  master_req,
    output master_resp,
    output slave_req,
    input  slave_resp,
    output busy,
    output err
  );

  modport slave (
    output master_req,
    input  master_resp,
    input  slave_req,
    output slave_resp,
    input  busy,
    input  err
  );

endinterface

// File: rtl/ao_periph_obi_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// ao_arb_id_fifo
// In-order tracker of granted requester IDs awaiting their rvalid.
//   push_i/push_id_i : record the ID of an accepted handshake
//   pop_i            : retire the head entry (ignored when empty)
//   full_o/empty_o   : occupancy == DEPTH / occupancy == 0
//   head_o           : ID that owns the next response
//   count_o          : registered occupancy
// A push while full is dropped; the arbiter never issues one.
// -----------------------------------------------------------------------------
module ao_arb_id_fifo #(
  parameter int DEPTH    = 2,
  parameter int ID_WIDTH = 1,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [ID_WIDTH-1:0] push_id_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [ID_WIDTH-1:0] head_o,
  output logic [CNT_W-1:0]    count_o
);

  logic [ID_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                do_push_s;
  logic                do_pop_s;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_r == CNT_W'(DEPTH));
  assign empty_o   = (count_r == '0);
  assign head_o    = mem_r[rd_ptr_r];
  assign count_o   = count_r;
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_id_i;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ao_periph_obi_arbiter.sv
// -----------------------------------------------------------------------------
// ao_periph_obi_arbiter
// Shares the always-on peripheral OBI slave port among NUM_REQ requesters.
// Zero-latency grant path; responses return in order via an ID tracker.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   master_req_i  : per-requester OBI requests
//   master_resp_o : per-requester gnt / rvalid / rdata
//   slave_req_o   : request forwarded to the AO peripheral slave
//   slave_resp_i  : slave gnt / rvalid / rdata
//   busy_o        : at least one transaction outstanding
//   err_o         : sticky, rvalid seen with nothing outstanding
// Build option AO_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin.
// -----------------------------------------------------------------------------
module ao_periph_obi_arbiter
  import obi_pkg::*;
  import ao_periph_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [NUM_REQ],
  output obi_resp_t master_resp_o [NUM_REQ],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int ID_W  = int'(arb_id_width(NUM_REQ));
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  win_id_s;
  logic             win_valid_s;
  logic [ID_W-1:0]  hold_id_r;
  logic             hold_r;
  logic [ID_W-1:0]  head_id_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] count_s;
  logic             issue_s;
  logic             accept_s;
  logic             pop_s;
  logic             err_r;
  tracker_entry_t   head_entry_s;

`ifndef AO_ARB_FIXED_PRIO_EN
  localparam int SUM_W = ID_W + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  ptr_r;
  logic [SUM_W-1:0] rr_sum_s;
`endif

  // Winner selection; a stalled request keeps the port until it is granted.
  always_comb begin
    win_valid_s = 1'b0;
    win_id_s    = '0;
`ifndef AO_ARB_FIXED_PRIO_EN
    rr_sum_s    = '0;
`endif
    if (hold_r && master_req_i[hold_id_r].req) begin
      win_valid_s = 1'b1;
      win_id_s    = hold_id_r;
    end else begin
      // Walk from the far end so the nearest requester overwrites last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef AO_ARB_FIXED_PRIO_EN
        if (master_req_i[i].req) begin
          win_valid_s = 1'b1;
          win_id_s    = ID_W'(i);
        end
`else
        rr_sum_s = {1'b0, ptr_r} + SUM_W'(i);
        if (rr_sum_s >= SUM_W'(NUM_REQ)) begin
          rr_sum_s = rr_sum_s - SUM_W'(NUM_REQ);
        end
        if (master_req_i[rr_sum_s[ID_W-1:0]].req) begin
          win_valid_s = 1'b1;
          win_id_s    = rr_sum_s[ID_W-1:0];
        end
`endif
      end
    end
  end

  // A full tracker blocks issue for the whole cycle, even if a pop coincides.
  assign issue_s  = win_valid_s && !fifo_full_s;
  assign accept_s = issue_s && slave_resp_i.gnt;
  assign pop_s    = slave_resp_i.rvalid && !fifo_empty_s;

  assign head_entry_s = tracker_entry_t'(head_id_s);

  // Request forwarding, grant steering and response routing.
  always_comb begin
    slave_req_o = '0;
    for (int i = 0; i < NUM_REQ; i++) master_resp_o[i] = '0;
    if (issue_s) begin
      slave_req_o                 = master_req_i[win_id_s];
      master_resp_o[win_id_s].gnt = slave_resp_i.gnt;
    end else begin
      slave_req_o = '0;
    end
    if (pop_s) begin
      master_resp_o[head_entry_s[ID_W-1:0]].rvalid = 1'b1;
      master_resp_o[head_entry_s[ID_W-1:0]].rdata  = slave_resp_i.rdata;
    end else begin
      slave_req_o.we = slave_req_o.we;
    end
  end

  ao_arb_id_fifo #(
    .DEPTH    (MAX_OUTSTANDING),
    .ID_WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (accept_s),
    .push_id_i (win_id_s),
    .pop_i     (pop_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .head_o    (head_id_s),
    .count_o   (count_s)
  );

  // Remember a presented-but-ungranted request so it stays on the port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_r    <= 1'b0;
      hold_id_r <= '0;
    end else begin
      hold_r    <= issue_s && !slave_resp_i.gnt;
      hold_id_r <= win_id_s;
    end
  end

`ifndef AO_ARB_FIXED_PRIO_EN
  // Round-robin pointer advances past the winner only on a completed handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= (win_id_s == LAST_ID) ? '0 : win_id_s + ID_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Sticky protocol error: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (slave_resp_i.rvalid && fifo_empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign busy_o = (count_s != '0);
  assign err_o  = err_r;

endmodule

// File: tb/tb_ao_periph_obi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ao_periph_obi_arbiter
// Directed self-checking bench for ao_periph_obi_arbiter with NUM_REQ=2,
// MAX_OUTSTANDING=2. Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_ao_periph_obi_arbiter;
  import obi_pkg::*;

  localparam logic [31:0] ADDR0 = 32'h2000_0000;
  localparam logic [31:0] ADDR1 = 32'h2000_0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  ao_periph_obi_arbiter_if #(.NUM_REQ(2)) bus ();

  ao_periph_obi_arbiter #(
    .NUM_REQ         (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .master_req_i  (bus.master_req),
    .master_resp_o (bus.master_resp),
    .slave_req_o   (bus.slave_req),
    .slave_resp_i  (bus.slave_resp),
    .busy_o        (bus.busy),
    .err_o         (bus.err)
  );

  always #5 clk = ~clk;

  function automatic obi_req_t mk_req(input logic on, input logic [31:0] addr);
    obi_req_t r;
    r = '0;
    if (on) begin
      r.req  = 1'b1;
      r.be   = 4'hF;
      r.addr = addr;
    end
    return r;
  endfunction

  function automatic logic [1:0] gnt_vec();
    return {bus.master_resp[1].gnt, bus.master_resp[0].gnt};
  endfunction

  function automatic logic [1:0] rv_vec();
    return {bus.master_resp[1].rvalid, bus.master_resp[0].rvalid};
  endfunction

  task automatic drive(input logic r0, input logic r1, input logic gnt,
                       input logic rvalid, input logic [31:0] rdata);
    @(negedge clk);
    bus.master_req[0]        = mk_req(r0, ADDR0);
    bus.master_req[1]        = mk_req(r1, ADDR1);
    bus.slave_resp.gnt       = gnt;
    bus.slave_resp.rvalid    = rvalid;
    bus.slave_resp.rdata     = rdata;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.slave_req !== obi_req_t'('0)) $display("FAIL reset_slave_req got=%h exp=0", bus.slave_req); else pass_cnt++;
    total_cnt++; if (gnt_vec() !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", gnt_vec()); else pass_cnt++;
    total_cnt++; if (rv_vec() !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", rv_vec()); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err); else pass_cnt++;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.slave_req.req !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL idle_after_reset got req=%b busy=%b err=%b exp=0/0/0", bus.slave_req.req, bus.busy, bus.err); else pass_cnt++;
  endtask

  // Both requesters continuously; slave grants every cycle and answers one cycle later.
  task automatic test_round_robin();
    int exp_w;
    int prev_w;
    logic [1:0] exp_g;
    prev_w = 0;
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, k < 4, 1'b1, k >= 1, 32'hA0 + 32'(prev_w));
`ifdef AO_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = k % 2;
`endif
      if (k < 4) begin
        exp_g = (exp_w == 0) ? 2'b01 : 2'b10;
        total_cnt++; if (bus.slave_req.addr !== ((exp_w == 0) ? ADDR0 : ADDR1))
          $display("FAIL rr_addr k=%0d got=%h exp=%h", k, bus.slave_req.addr, (exp_w == 0) ? ADDR0 : ADDR1); else pass_cnt++;
        total_cnt++; if (gnt_vec() !== exp_g) $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt_vec(), exp_g); else pass_cnt++;
      end else begin
        total_cnt++; if (bus.slave_req.req !== 1'b0) $display("FAIL rr_idle_req got=%b exp=0", bus.slave_req.req); else pass_cnt++;
      end
      if (k >= 1) begin
        total_cnt++; if (rv_vec() !== ((prev_w == 0) ? 2'b01 : 2'b10))
          $display("FAIL rr_rvalid k=%0d got=%b exp_owner=%0d", k, rv_vec(), prev_w); else pass_cnt++;
        total_cnt++; if (bus.master_resp[prev_w].rdata !== 32'hA0 + 32'(prev_w) || bus.master_resp[1 - prev_w].rdata !== 32'h0)
          $display("FAIL rr_rdata k=%0d got=%h/%h exp_owner=%0d", k, bus.master_resp[0].rdata, bus.master_resp[1].rdata, prev_w); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rr_busy k=%0d got=%b exp=1", k, bus.busy); else pass_cnt++;
      end
      prev_w = exp_w;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rr_drained_busy got=%b exp=0", bus.busy); else pass_cnt++;
  endtask

  // Requester 0 only, rvalid withheld until the tracker has been full for 5 cycles.
  task automatic test_outstanding_limit();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      total_cnt++; if (gnt_vec() !== 2'b01 || bus.slave_req.req !== 1'b1)
        $display("FAIL lim_grant k=%0d got gnt=%b req=%b exp=01/1", k, gnt_vec(), bus.slave_req.req); else pass_cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      total_cnt++; if (bus.slave_req.req !== 1'b0 || gnt_vec() !== 2'b00 || bus.busy !== 1'b1)
        $display("FAIL lim_full k=%0d got req=%b gnt=%b busy=%b exp=0/00/1", k, bus.slave_req.req, gnt_vec(), bus.busy); else pass_cnt++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h55);
    total_cnt++; if (bus.slave_req.req !== 1'b0 || gnt_vec() !== 2'b00)
      $display("FAIL lim_pop_cycle_blocked got req=%b gnt=%b exp=0/00", bus.slave_req.req, gnt_vec()); else pass_cnt++;
    total_cnt++; if (rv_vec() !== 2'b01 || bus.master_resp[0].rdata !== 32'h55)
      $display("FAIL lim_pop_route got rv=%b rdata=%h exp=01/55", rv_vec(), bus.master_resp[0].rdata); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    total_cnt++; if (bus.slave_req.req !== 1'b1 || gnt_vec() !== 2'b01)
      $display("FAIL lim_resume got req=%b gnt=%b exp=1/01", bus.slave_req.req, gnt_vec()); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h66);
      total_cnt++; if (rv_vec() !== 2'b01) $display("FAIL lim_drain k=%0d got=%b exp=01", k, rv_vec()); else pass_cnt++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL lim_busy_end got=%b exp=0", bus.busy); else pass_cnt++;
  endtask

  // Requester 1 stalled by gnt=0 must keep the port even though requester 0 has priority.
  task automatic test_hold();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    total_cnt++; if (gnt_vec() !== 2'b10) $display("FAIL hold_setup_gnt got=%b exp=10", gnt_vec()); else pass_cnt++;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h77);
    total_cnt++; if (rv_vec() !== 2'b10 || bus.master_resp[1].rdata !== 32'h77)
      $display("FAIL hold_setup_rv got rv=%b rdata=%h exp=10/77", rv_vec(), bus.master_resp[1].rdata); else pass_cnt++;
    total_cnt++; if (bus.slave_req.addr !== ADDR1 || gnt_vec() !== 2'b00)
      $display("FAIL hold_c0 got addr=%h gnt=%b exp=%h/00", bus.slave_req.addr, gnt_vec(), ADDR1); else pass_cnt++;
    for (int k = 1; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      total_cnt++; if (bus.slave_req.addr !== ADDR1 || bus.slave_req.req !== 1'b1 || gnt_vec() !== 2'b00)
        $display("FAIL hold_c%0d got addr=%h req=%b gnt=%b exp=%h/1/00", k, bus.slave_req.addr, bus.slave_req.req, gnt_vec(), ADDR1); else pass_cnt++;
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    total_cnt++; if (bus.slave_req.addr !== ADDR1 || gnt_vec() !== 2'b10)
      $display("FAIL hold_granted got addr=%h gnt=%b exp=%h/10", bus.slave_req.addr, gnt_vec(), ADDR1); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h88);
    total_cnt++; if (bus.slave_req.addr !== ADDR0 || gnt_vec() !== 2'b01)
      $display("FAIL hold_next got addr=%h gnt=%b exp=%h/01", bus.slave_req.addr, gnt_vec(), ADDR0); else pass_cnt++;
    total_cnt++; if (rv_vec() !== 2'b10 || bus.master_resp[1].rdata !== 32'h88)
      $display("FAIL hold_resp1 got rv=%b rdata=%h exp=10/88", rv_vec(), bus.master_resp[1].rdata); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
    total_cnt++; if (rv_vec() !== 2'b01 || bus.master_resp[0].rdata !== 32'h99)
      $display("FAIL hold_resp0 got rv=%b rdata=%h exp=01/99", rv_vec(), bus.master_resp[0].rdata); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL hold_busy_end got=%b exp=0", bus.busy); else pass_cnt++;
  endtask

  // Stray rvalid with an empty tracker: routed nowhere, err sticks until reset.
  task automatic test_err();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD);
    total_cnt++; if (rv_vec() !== 2'b00 || bus.master_resp[0].rdata !== 32'h0 || bus.master_resp[1].rdata !== 32'h0)
      $display("FAIL err_no_route got rv=%b rdata=%h/%h exp=00/0/0", rv_vec(), bus.master_resp[0].rdata, bus.master_resp[1].rdata); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.err !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL err_set got err=%b busy=%b exp=1/0", bus.err, bus.busy); else pass_cnt++;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", bus.err); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL err_reset_clear got=%b exp=0", bus.err); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  // Reset with a transaction in flight; the late response must be an error.
  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", bus.busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mid_busy_async_clear got=%b exp=0", bus.busy); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h12);
    total_cnt++; if (rv_vec() !== 2'b00) $display("FAIL mid_late_rv got=%b exp=00", rv_vec()); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL mid_late_err got=%b exp=1", bus.err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding_limit();
    test_hold();
    test_err();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d/%0d checks", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ao_periph_obi_arbiter.md
AO_PERIPH_OBI_ARBITER -- requirements
Module: ao_periph_obi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of OBI requesters sharing the always-on peripheral slave port (range 2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted-but-unanswered transactions (range 1..4).
REQ-003 SHALL have port clk_i, input, 1, the single clock; one clock domain, no other clocks.
REQ-004 SHALL have port rst_i, input, 1, the reset; asynchronous, active-high.
REQ-005 SHALL have port master_req_i, input, NUM_REQ x obi_req_t, the requester-side OBI requests.
REQ-006 SHALL have port master_resp_o, output, NUM_REQ x obi_resp_t, the requester-side gnt/rvalid/rdata.
REQ-007 SHALL have port slave_req_o, output, obi_req_t, the request to the AO peripheral subsystem slave port.
REQ-008 SHALL have port slave_resp_i, input, obi_resp_t, the response from the AO peripheral subsystem.
REQ-009 SHALL have port busy_o, output, 1, high while at least one transaction is outstanding.
REQ-010 SHALL have port err_o, output, 1, sticky flag set by an rvalid received with no outstanding transaction.

Function
REQ-011 SHALL choose a winner combinationally each cycle among requesters with req=1; slave_req_o SHALL equal the winner's request, with req=0 and all other fields 0 when there is no winner or the tracker is full.
REQ-012 SHALL assert master_resp_o[w].gnt = slave_resp_i.gnt only for winner w; gnt SHALL be 0 for all other requesters; zero-cycle grant latency.
REQ-013 SHALL arbitrate round-robin: the priority pointer moves to (w+1) mod NUM_REQ only on an accepted handshake (slave req and gnt both high); it SHALL hold when a request is not granted.
REQ-014 SHALL keep a winner's request on slave_req_o until it is granted (no re-arbitration while slave_req_o.req=1 and gnt=0), so OBI request stability holds.
REQ-015 SHALL push the winner index into an in-order ID tracker on each accepted handshake; it SHALL pop on each slave_resp_i.rvalid.
REQ-016 SHALL route rvalid and rdata to the requester at the tracker head in the same cycle; all other requesters SHALL see rvalid=0 and rdata=0.
REQ-017 Tracker full (MAX_OUTSTANDING entries): SHALL drive slave_req_o.req=0 and issue no grants, even if an rvalid pops in the same cycle; grants resume the following cycle.
REQ-018 Tracker empty and rvalid=1: SHALL route the response to no requester, leave the tracker empty, and set err_o.
REQ-019 Simultaneous push and pop with the tracker not full: SHALL perform both; occupancy is unchanged.
REQ-020 busy_o SHALL be 1 exactly while tracker occupancy is greater than 0 (registered occupancy).

Reset
REQ-021 On rst_i assertion the block SHALL asynchronously set pointer=0, tracker empty, err_o=0 and busy_o=0; combinational outputs follow (slave req=0, all gnt/rvalid=0 unless inputs demand otherwise).
REQ-022 Reset mid-operation SHALL discard in-flight IDs; a late rvalid after reset SHALL be treated per REQ-018.
REQ-023 err_o SHALL clear only by reset.

Configuration
REQ-024 With macro AO_ARB_FIXED_PRIO_EN defined, the block SHALL use fixed priority (lowest requesting index wins) and SHALL not implement the pointer; without it, it SHALL use the round-robin behaviour of REQ-013.

Structure
REQ-025 Package ao_periph_arb_pkg SHALL hold the ID width function/constant (clog2 of NUM_REQ, minimum 1) and the tracker-entry typedef; obi_pkg types are reused unchanged.
REQ-026 The in-order ID tracker SHALL be the sub-module ao_arb_id_fifo (parameters DEPTH, ID_WIDTH; push/pop/full/empty/head/count).

Verification
REQ-027 Reset then idle: all outputs 0, busy_o=0, err_o=0.
REQ-028 NUM_REQ=2, both requesting continuously, gnt=1 and rvalid one cycle later: grants alternate 0,1,0,1; each rdata (0xA0+idx) is returned only to its issuer.
REQ-029 MAX_OUTSTANDING=2, gnt=1 with rvalid withheld: two grants, then slave req=0 for 5 cycles; a single rvalid re-enables grants on the next cycle.
REQ-030 Requester 1 pending with gnt=0 for 3 cycles while requester 0 asserts req: slave_req_o stays on requester 1's address (0x2000_0004) until granted.
REQ-031 rvalid injected with the tracker empty: no master sees rvalid, err_o=1 and stays 1 until rst_i.
REQ-032 Build with AO_ARB_FIXED_PRIO_EN, both requesting: requester 0 wins every cycle; without the macro, the REQ-028 alternation holds.
